jtag_vector_sequencer: RTL
==========================

Name: jtag_vector_sequencer

Overview:
- Plays a stored JTAG vector stream. Reads one byte per TCK cycle from the vector_1 RAM byte port and drives TCK/TMS/TDI from it.
- Samples TDO on each cycle and writes one result byte per vector into the vector_2 RAM byte port.
- Sits between the CPU-side control registers (start/abort, length, TCK width) and the dual-port vector RAMs, in the vector_ram_clk domain.

Parameters:
ADDR_W, 12, vector/result byte address width
HALF_W, 16, width of the TCK half-period count

Ports:
clk  in  1  sequencer clock (vector_ram_clk domain)
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle run request
abort  in  1  single-cycle run cancel
vec_last  in  ADDR_W  index of last vector; a run covers vec_last+1 vectors
tck_half  in  HALF_W  clocks per TCK high phase and per counted low phase; 0 treated as 1
vec_addr  out  ADDR_W  vector_1 read address
vec_rd_data  in  8  vector_1 read data, valid 1 clk after vec_addr
res_addr  out  ADDR_W  vector_2 write address
res_we  out  1  vector_2 write strobe
res_wr_data  out  8  vector_2 write data
tdo  in  1  target TDO, already synchronised to clk
tck  out  1  JTAG clock
tms  out  1  JTAG TMS
tdi  out  1  JTAG TDI
busy  out  1  run in progress
done  out  1  1-clk pulse at normal completion

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, busy=0, done=0, res_we=0, vec_addr=0, res_addr=0, res_wr_data=0, state=IDLE.
- Vector byte format: bit0=TMS, bit1=TDI, bits7:2 user tag, carried unchanged into the result.
- Result byte = {vec[7:1], tdo_sample}.
- vec_last and tck_half are latched on an accepted start. Later changes to either have no effect until the next run.
- FSM states: IDLE, FETCH, LOAD, LOW, HIGH, DONE.
- IDLE: start=1 -> latch inputs, idx=0, vec_addr=0, busy=1, go to FETCH. start is ignored in all other states.
- FETCH (1 clk): waits for RAM read latency. tck=0.
- LOAD (1 clk): registers tms=vec_rd_data[0], tdi=vec_rd_data[1] and the tag; tck stays 0; go to LOW.
- LOW (tck_half clks): tck=0. In its final cycle, tdo is registered as tdo_sample. Then go to HIGH.
- HIGH (tck_half clks):
  - tck=1.
  - In the first HIGH cycle: res_we=1 for exactly 1 clk, res_addr=idx, res_wr_data=result byte.
  - At the end of HIGH, if idx==vec_last go to DONE. Otherwise idx+1, vec_addr=idx+1, go to FETCH.
- DONE (1 clk): done=1, busy=0, tck=0, go to IDLE.
- TCK period per vector = 2*tck_half+2 clks: low for tck_half+2, high for tck_half.
- Counter width rule: the half-period counter is HALF_W bits and counts down from tck_half-1. idx is ADDR_W bits.
- vec_last = 2^ADDR_W-1 runs the full RAM. idx never wraps within a run.
- Abort in any non-IDLE state returns to IDLE on the next edge:
  - tck=0, busy=0, res_we=0, no done pulse.
  - tms/tdi hold their last values.
- Abort wins over start in the same cycle. Abort in IDLE has no effect.
- Asynchronous reset mid-run forces all reset values immediately. A partially completed run is not resumed.
- res_we is never asserted outside HIGH. Exactly vec_last+1 writes occur per completed run.

Optional Feature:
- Macro: JTAG_SEQ_ADC_TRIG_EN.
- When defined, the following are added:
  - Ports adc_delay (in, 32) and adc_trig (out, 1, reset 0).
  - A vector with bit7=1 loads a 32-bit down-counter with adc_delay on its LOAD cycle.
  - adc_trig pulses for 1 clk when the counter reaches 0. adc_delay=0 pulses on the clk after LOAD.
  - A new bit7 vector arriving while the counter is running reloads the counter; only one pulse results.
  - Abort or reset clears the counter with no pulse.
- When undefined: no extra ports or logic, and bit7 is an ordinary tag bit.

Test Plan:
1. Reset, then start with vec_last=3, tck_half=2, vector RAM = 01,03,02,00, tdo held 1:
   - tck period 6 clks, tms/tdi follow the bytes.
   - Result RAM = 01,03,03,01.
   - done pulses once, 24 clks after the first FETCH.
2. tck_half=0 with vec_last=0:
   - Behaves as tck_half=1: tck high 1 clk, low 3 clks.
   - One write to res_addr 0.
3. tdo toggled so it is 1 only in the final LOW cycle of vector 1 (vec_last=2):
   - Result bit0 pattern 0,1,0.
   - Vector tags 0xA8,0x54,0xFC are preserved in bits 7:2.
4. Abort asserted in the HIGH phase of vector 2 of 5:
   - busy=0 and tck=0 next clk.
   - Exactly 3 result writes, no done pulse.
   - A subsequent start runs cleanly from idx 0.
5. start held high and vec_last changed mid-run:
   - No restart occurs, and the original latched length completes.
   - Assert reset_n low mid-run: all outputs take their reset values asynchronously, with tms=1.
6. With JTAG_SEQ_ADC_TRIG_EN, vector 1 = 0x80, adc_delay=5:
   - adc_trig pulses exactly once, 6 clks after that vector's LOAD cycle.
   - No pulse for vectors with bit7=0.

Source files
------------

// File: rtl/jtag_vector_sequencer_if.sv
// Vector/result RAM byte-port bundle between the JTAG sequencer (master) and the
// dual-port vector RAMs (slave).
interface jtag_vector_sequencer_if #(
    parameter int ADDR_W = 12
) ();
    logic [ADDR_W-1:0] vec_addr;
    logic [7:0]        vec_rd_data;
    logic [ADDR_W-1:0] res_addr;
    logic              res_we;
    logic [7:0]        res_wr_data;

    modport master (
        output vec_addr,
        output res_addr,
        output res_we,
        output res_wr_data,
        input  vec_rd_data
    );

    modport slave (
        input  vec_addr,
        input  res_addr,
        input  res_we,
        input  res_wr_data,
        output vec_rd_data
    );
endinterface

// File: rtl/jtag_vector_sequencer.sv
// Plays stored JTAG vectors onto TCK/TMS/TDI and writes one TDO result byte per vector.
// Define JTAG_SEQ_ADC_TRIG_EN to add the delayed ADC trigger on bit7-tagged vectors.
module jtag_vector_sequencer #(
    parameter int ADDR_W = 12,
    parameter int HALF_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_W-1:0]       vec_last,
    input  logic [HALF_W-1:0]       tck_half,
    jtag_vector_sequencer_if.master ram,
    input  logic                    tdo,
    output logic                    tck,
    output logic                    tms,
    output logic                    tdi,
    output logic                    busy,
`ifdef JTAG_SEQ_ADC_TRIG_EN
    output logic                    done,
    input  logic [31:0]             adc_delay,
    output logic                    adc_trig
`else
    output logic                    done
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, LOW, HIGH, DONE} state_t;

    localparam logic [HALF_W-1:0] HALF_ONE = HALF_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic [ADDR_W-1:0] vec_addr_q, vec_addr_nxt;
    logic [ADDR_W-1:0] res_addr_q, res_addr_nxt;
    logic              res_we_q, res_we_nxt;
    logic              tck_nxt, tms_nxt, tdi_nxt, busy_nxt, done_nxt;
    logic [6:0]        vec_hi_q, vec_hi_nxt;
    logic              tdo_sample, tdo_sample_nxt;
    logic [ADDR_W-1:0] last_q, last_nxt;
    logic [HALF_W-1:0] half_q, half_nxt;
    logic [HALF_W-1:0] cnt, cnt_nxt;
    logic              abort_run;

    assign abort_run = abort && (state != IDLE);

    assign ram.vec_addr    = vec_addr_q;
    assign ram.res_addr    = res_addr_q;
    assign ram.res_we      = res_we_q;
    // Result byte is the vector's upper seven bits with the sampled TDO in bit0.
    assign ram.res_wr_data = {vec_hi_q, tdo_sample};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            vec_addr_q <= '0;
            res_addr_q <= '0;
            res_we_q   <= 1'b0;
            tck        <= 1'b0;
            tms        <= 1'b1;
            tdi        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vec_hi_q   <= '0;
            tdo_sample <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            vec_addr_q <= vec_addr_nxt;
            res_addr_q <= res_addr_nxt;
            res_we_q   <= res_we_nxt;
            tck        <= tck_nxt;
            tms        <= tms_nxt;
            tdi        <= tdi_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            vec_hi_q   <= vec_hi_nxt;
            tdo_sample <= tdo_sample_nxt;
        end
    end

    // Run length, half period and phase counter carry no control meaning outside a run.
    always_ff @(posedge clk) begin
        last_q <= last_nxt;
        half_q <= half_nxt;
        cnt    <= cnt_nxt;
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        vec_addr_nxt   = vec_addr_q;
        res_addr_nxt   = res_addr_q;
        res_we_nxt     = 1'b0;
        tck_nxt        = tck;
        tms_nxt        = tms;
        tdi_nxt        = tdi;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        vec_hi_nxt     = vec_hi_q;
        tdo_sample_nxt = tdo_sample;
        last_nxt       = last_q;
        half_nxt       = half_q;
        cnt_nxt        = cnt;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    last_nxt     = vec_last;
                    half_nxt     = (tck_half == '0) ? HALF_ONE : tck_half;
                    idx_nxt      = '0;
                    vec_addr_nxt = '0;
                    busy_nxt     = 1'b1;
                    tck_nxt      = 1'b0;
                    state_nxt    = FETCH;
                end
            end
            FETCH: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                tms_nxt    = ram.vec_rd_data[0];
                tdi_nxt    = ram.vec_rd_data[1];
                vec_hi_nxt = ram.vec_rd_data[7:1];
                cnt_nxt    = half_q - HALF_ONE;
                state_nxt  = LOW;
            end
            LOW: begin
                if (cnt == '0) begin
                    tdo_sample_nxt = tdo;
                    tck_nxt        = 1'b1;
                    res_we_nxt     = 1'b1;
                    res_addr_nxt   = idx;
                    cnt_nxt        = half_q - HALF_ONE;
                    state_nxt      = HIGH;
                end else begin
                    cnt_nxt = cnt - HALF_ONE;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    tck_nxt = 1'b0;
                    // Comparing before incrementing keeps idx from wrapping on a full-RAM run.
                    if (idx == last_q) begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = DONE;
                    end else begin
                        idx_nxt      = idx + ADDR_ONE;
                        vec_addr_nxt = idx + ADDR_ONE;
                        state_nxt    = FETCH;
                    end
                end else begin
                    cnt_nxt = cnt - HALF_ONE;
                end
            end
            DONE: begin
                tck_nxt   = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Cancel keeps TMS/TDI where they were so the target sees no spurious edge.
        if (abort_run) begin
            state_nxt  = IDLE;
            tck_nxt    = 1'b0;
            busy_nxt   = 1'b0;
            res_we_nxt = 1'b0;
            done_nxt   = 1'b0;
        end
    end

`ifdef JTAG_SEQ_ADC_TRIG_EN
    logic [31:0] adc_cnt;
    logic        adc_run;

    // A fresh bit7 vector restarts the delay; a pending expiry in the same cycle is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc_cnt  <= '0;
            adc_run  <= 1'b0;
            adc_trig <= 1'b0;
        end else begin
            adc_trig <= 1'b0;
            if (abort_run) begin
                adc_cnt <= '0;
                adc_run <= 1'b0;
            end else if (state == LOAD && ram.vec_rd_data[7]) begin
                if (adc_delay == 32'd0) begin
                    adc_trig <= 1'b1;
                    adc_run  <= 1'b0;
                end else begin
                    adc_cnt <= adc_delay - 32'd1;
                    adc_run <= 1'b1;
                end
            end else if (adc_run) begin
                if (adc_cnt == 32'd0) begin
                    adc_trig <= 1'b1;
                    adc_run  <= 1'b0;
                end else begin
                    adc_cnt <= adc_cnt - 32'd1;
                end
            end
        end
    end
`endif

endmodule
